// File: rtl/gpio_config_serializer.sv
// gpio_config_serializer: streams per-pad config words MSB-first into the GPIO control chain, then latches
module gpio_config_serializer #(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV = 2,
  localparam int IDX_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                clock,
  input  logic                resetb,
  input  logic                xfer_start,
  input  logic [CFG_BITS-1:0] cfg_word,
  output logic [IDX_W-1:0]    cfg_idx,
  output logic                busy,
  output logic                done,
  output logic                serial_clock,
  output logic                serial_data,
  output logic                serial_load,
  output logic                serial_resetn
);
  localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] pad_q, pad_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic [CFG_BITS-1:0] sr_q, sr_d;
  logic srn_q;
  logic phase_end;
  assign phase_end = div_q == DW'(CLK_DIV - 1);
  assign cfg_idx = (state_q == FETCH) ? pad_q : '0;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign serial_clock = state_q == SHIFT_HI;
  assign serial_data = (state_q == SHIFT_LO || state_q == SHIFT_HI) && sr_q[CFG_BITS-1];
  assign serial_load = state_q == LATCH;
  assign serial_resetn = srn_q;
  // State, counters and shift register; chain reset releases on the first edge out of reset
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) begin
      state_q <= IDLE;
      pad_q <= '0;
      bit_q <= '0;
      div_q <= '0;
      sr_q <= '0;
      srn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pad_q <= pad_d;
      bit_q <= bit_d;
      div_q <= div_d;
      sr_q <= sr_d;
      srn_q <= 1'b1;
    end
  // Next state: divider counts within a phase and restarts on every state entry
  always_comb begin
    state_d = state_q;
    pad_d = pad_q;
    bit_d = bit_q;
    sr_d = sr_q;
    div_d = div_q + 1'b1;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (xfer_start) begin
          state_d = FETCH;
          pad_d = IDX_W'(NUM_PADS - 1);
        end
      end
      FETCH: begin
        sr_d = cfg_word;
        bit_d = BW'(CFG_BITS - 1);
        div_d = '0;
        state_d = SHIFT_LO;
      end
      SHIFT_LO: if (phase_end) begin
        div_d = '0;
        state_d = SHIFT_HI;
      end
      SHIFT_HI: if (phase_end) begin
        div_d = '0;
        sr_d = sr_q << 1;
        bit_d = bit_q - 1'b1;
        if (bit_q != '0) state_d = SHIFT_LO;
        else if (pad_q != '0) begin
          pad_d = pad_q - 1'b1;
          state_d = FETCH;
        end else state_d = LATCH;
      end
      LATCH: if (phase_end) begin
        div_d = '0;
        state_d = DONE;
      end
      default: begin
        div_d = '0;
        state_d = IDLE;
      end
    endcase
  end
endmodule
